load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_if.sv | 49 ++++
 rtl/load_store_unit_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access widths, FSM states and the
// default addresses of the memory-mapped cycle counter and UART.
package BasicTypes;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [31:0] HC_ADDR_DEF   = 32'hFFFF_FF00;
  localparam logic [31:0] UART_ADDR_DEF = 32'hFFFF_FF04;

  // The reserved width encoding is treated like a word for alignment.
  function automatic logic misaligned(input width_e w, input logic [1:0] a);
    return (w == W_HALF && a[0]) || (w[1] && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response, memory bus and UART signals of the load/store unit.
// The unit itself uses the slave modport; the requester/memory side uses master.
interface lsu_if #(
    parameter int ADDR_W    = 32,
    parameter int BUS_BYTES = 4
);
    localparam int OFFW = $clog2(BUS_BYTES);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_is_load;
    logic                    req_is_store;
    logic                    req_unsigned;
    logic [1:0]              req_width;
    logic [ADDR_W-1:0]       req_addr;
    logic [31:0]             req_wdata;
    logic [4:0]              req_rd;

    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic [4:0]              rsp_rd;
    logic                    rsp_err;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_we;
    logic [BUS_BYTES-1:0]    mem_be;
    logic [ADDR_W-OFFW-1:0]  mem_addr;
    logic [8*BUS_BYTES-1:0]  mem_wdata;
    logic                    mem_rsp_valid;
    logic [8*BUS_BYTES-1:0]  mem_rdata;

    logic [7:0]              uart_data;
    logic                    uart_we;

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_unsigned, req_width,
               req_addr, req_wdata, req_rd, mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err, mem_req_valid,
               mem_we, mem_be, mem_addr, mem_wdata, uart_data, uart_we
    );

    modport master (
        output req_valid, req_is_load, req_is_store, req_unsigned, req_width,
               req_addr, req_wdata, req_rd, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err, mem_req_valid,
               mem_we, mem_be, mem_addr, mem_wdata, uart_data, uart_we
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Picks the byte/half/word at the request offset out of a memory line and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
    import BasicTypes::*;
#(
    parameter  int BUS_BYTES = 4,
    localparam int OFFW      = $clog2(BUS_BYTES)
) (
    input  logic [8*BUS_BYTES-1:0] line_i,
    input  logic [OFFW-1:0]        off_i,
    input  width_e                 width_i,
    input  logic                   unsigned_i,
    output logic [31:0]            data_o
);
    logic [31:0] low;

    assign low = 32'(line_i >> {off_i, 3'b000});

    always_comb begin
        data_o = low;
        case (width_i)
            W_BYTE:  data_o = {{24{~unsigned_i & low[7]}}, low[7:0]};
            W_HALF:  data_o = {{16{~unsigned_i & low[15]}}, low[15:0]};
            default: data_o = low;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns accesses onto a BUS_BYTES-wide
// memory bus and short-circuits the cycle counter, UART and pass-through ops.
module load_store_unit
    import BasicTypes::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               BUS_BYTES = 4,
    parameter int               TIMEOUT   = 255,
    parameter logic [ADDR_W-1:0] HC_ADDR   = ADDR_W'(HC_ADDR_DEF),
    parameter logic [ADDR_W-1:0] UART_ADDR = ADDR_W'(UART_ADDR_DEF)
) (
    input logic   clk,
    input logic   rst,
    lsu_if.slave  bus
);
    localparam int OFFW = $clog2(BUS_BYTES);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int DW   = 8 * BUS_BYTES;
    localparam int MAW  = ADDR_W - OFFW;

    lsu_state_e           state_q;
    logic                 req_ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0]          rsp_rdata_q;
    logic [4:0]           rsp_rd_q;
    logic                 mem_req_valid_q, mem_we_q;
    logic [BUS_BYTES-1:0] mem_be_q;
    logic [MAW-1:0]       mem_addr_q;
    logic [DW-1:0]        mem_wdata_q;
    logic                 uart_we_q;
    logic [7:0]           uart_data_q;
    logic [TW-1:0]        tmo_q;
    logic [31:0]          cyc_q;
    width_e               lat_width_q;
    logic                 lat_uns_q;
    logic [OFFW-1:0]      lat_off_q;

    width_e               req_w;
    logic                 is_ld, is_st, mem_op, misal, hc_hit, uart_hit;
    logic [BUS_BYTES-1:0] be_base, be_d;
    logic [DW-1:0]        wdata_d;
    logic [31:0]          ld_data;

    assign req_w    = width_e'(bus.req_width);
    assign is_ld    = bus.req_is_load;
    assign is_st    = bus.req_is_store & ~bus.req_is_load;
    assign mem_op   = is_ld | is_st;
    assign misal    = mem_op & misaligned(req_w, bus.req_addr[1:0]);
    assign hc_hit   = is_ld && (bus.req_addr == HC_ADDR);
    assign uart_hit = is_st && (bus.req_addr == UART_ADDR);

    // Replicating the store data across the line already lands it on the
    // addressed lane for any aligned access; the byte enables pick the lane.
    always_comb begin
        be_base = BUS_BYTES'(4'hF);
        wdata_d = {(BUS_BYTES/4){bus.req_wdata}};
        case (req_w)
            W_BYTE: begin
                be_base = BUS_BYTES'(1);
                wdata_d = {BUS_BYTES{bus.req_wdata[7:0]}};
            end
            W_HALF: begin
                be_base = BUS_BYTES'(3);
                wdata_d = {(BUS_BYTES/2){bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
        be_d = be_base << bus.req_addr[OFFW-1:0];
    end

    lsu_load_align #(.BUS_BYTES(BUS_BYTES)) u_align (
        .line_i     (bus.mem_rdata),
        .off_i      (lat_off_q),
        .width_i    (lat_width_q),
        .unsigned_i (lat_uns_q),
        .data_o     (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_rd_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_be_q        <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            uart_we_q       <= 1'b0;
            uart_data_q     <= '0;
            tmo_q           <= '0;
            lat_width_q     <= W_BYTE;
            lat_uns_q       <= 1'b0;
            lat_off_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            uart_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    req_ready_q <= 1'b0;
                    rsp_rd_q    <= bus.req_rd;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    lat_width_q <= req_w;
                    lat_uns_q   <= bus.req_unsigned;
                    lat_off_q   <= bus.req_addr[OFFW-1:0];
                    if (misal || hc_hit || uart_hit || !mem_op) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= misal;
                        if (hc_hit && !misal) rsp_rdata_q <= cyc_q;
                        if (!mem_op)          rsp_rdata_q <= 32'(bus.req_addr);
                        if (uart_hit && !misal) begin
                            uart_we_q   <= 1'b1;
                            uart_data_q <= bus.req_wdata[7:0];
                        end
                    end else begin
                        state_q         <= S_ISSUE;
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= is_st;
                        mem_be_q        <= be_d;
                        mem_addr_q      <= bus.req_addr[ADDR_W-1:OFFW];
                        mem_wdata_q     <= wdata_d;
                    end
                end
                S_ISSUE: if (bus.mem_req_ready) begin
                    mem_req_valid_q <= 1'b0;
                    tmo_q           <= '0;
                    if (mem_we_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_rd        = rsp_rd_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.uart_we       = uart_we_q;
    assign bus.uart_data     = uart_data_q;
endmodule
